alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, handshaked successor to the single-cycle execute ALU, adding the RV32M/RV64M multiply/divide operations. It sits in the EX stage between the ID/EX pipeline register and the EX/MEM register.
- Base integer ops complete with 1-cycle registered latency.
- MUL*/DIV*/REM* run on an iterative radix-2 datapath for XLEN cycles.
- A valid/ready handshake on both sides lets the pipeline stall on busy.

## Interface
- XLEN, 32, datapath width; power of two, 8..64
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; forced 0 while rst high
- op  in  5  operation code from shared package
- src1, src2  in  XLEN  operands
- out_valid  out  1  result/zero valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)
- busy  out  1  iterative op in progress

## Operation
- Op codes 0-11 are base ops: ADD, SUB, SLT, SLTU, GE, GEU, AND, OR, XOR, SLL, SRL, SRA.
  - Compares return 0/1 zero-extended to XLEN.
  - Shifts use src2[SHW-1:0].
  - SRA is arithmetic.
- Op codes 16-23 are M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Any other code: result 0, latency 1.
- FSM states: IDLE, ITER, HOLD.
  - IDLE: in_ready=1; accept moves to ITER for M ops, to HOLD for base ops and special-case M ops.
  - ITER: busy=1, in_ready=0; a counter runs XLEN-1 down to 0; at 0, the sign fixup is applied and the state moves to HOLD.
  - HOLD: out_valid=1; result and zero stay stable until out_ready. in_ready = out_ready, so a new op may be accepted in the same cycle the result is consumed (back-to-back).
  - HOLD with out_ready and no accept returns to IDLE.
- Multiply uses shift-add on magnitudes into a 2*XLEN product.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
  - Signed operands are converted to magnitude at accept; the product is negated at completion when the operand signs differ (src2 is treated as unsigned for MULHSU).
- Divide uses restoring division on magnitudes.
  - Quotient sign = sign1 XOR sign2; remainder sign = sign of dividend.
- Special cases (no ITER, latency 1):
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = src1.
  - Signed overflow (src1 = most-negative, src2 = -1): DIV = most-negative, REM = 0.
- Operands are captured at accept; src1/src2/op may change afterwards.

## Timing
- Reset values: out_valid=0, result=0, zero=1, busy=0, state=IDLE, counter=0.
- Reset mid-ITER or mid-HOLD aborts the op and discards the result; in_ready=1 on the first cycle after rst deasserts.
- Latency:
  - Base/special op accepted at edge N: out_valid=1 after edge N.
  - Iterative op accepted at edge N: busy=1 after edges N..N+XLEN-1; out_valid=1 after edge N+XLEN.
- out_valid never drops without out_ready=1 at a rising edge.
- Throughput:
  - Base ops: 1 per cycle with out_ready held high.
  - M ops: 1 per XLEN+1 cycles.
- in_valid while in_ready=0: ignored; the producer holds the op.

## Structure
- Shared package alu_pkg holds:
  - op_e enum with the codes above;
  - default XLEN;
  - is_mdu_op() and is_signed_src1/src2() helper functions.
- Top level alu_mdu contains the FSM, handshake, base-op combinational unit and output registers.
- Sub-module muldiv_iter contains the iterative datapath: 2*XLEN accumulator, counter, sign fixup and done pulse. It is parametrised by XLEN.

## Test plan
- XLEN=32, back-to-back ADD 5+7, SUB 3-5, SRA 0x80000000>>>4 with out_ready=1: results 12, 0xFFFFFFFE, 0xF8000000 on 3 consecutive cycles; zero=0.
- MULH 0xFFFFFFFF*2 (signed, -1*2): result 0xFFFFFFFF; busy for 32 cycles; out_valid on cycle 33; MUL of the same operands returns 0xFFFFFFFE.
- DIV -7/2 = 0xFFFFFFFD, REM -7/2 = 0xFFFFFFFF; DIVU 7/0 = 0xFFFFFFFF, REM 7/0 = 7; DIV 0x80000000/-1 = 0x80000000 with latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after the MUL result → result stable, in_ready=0; raise out_ready together with in_valid → the new op is accepted on that edge.
- Assert rst at ITER cycle 15 → out_valid=0, busy=0 immediately; a following ADD 1+1 yields 2 with latency 1.
- XLEN=64: MULHU all-ones × all-ones = 0xFFFFFFFFFFFFFFFE, latency 65; SLL shift 63 uses 6 bits.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU with RV32M/RV64M multiply/divide.
// Op codes, default width and op-classification helpers.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OPW          = 5;

  typedef enum logic [OPW-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLT    = 5'd2,
    OP_SLTU   = 5'd3,
    OP_GE     = 5'd4,
    OP_GEU    = 5'd5,
    OP_AND    = 5'd6,
    OP_OR     = 5'd7,
    OP_XOR    = 5'd8,
    OP_SLL    = 5'd9,
    OP_SRL    = 5'd10,
    OP_SRA    = 5'd11,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } op_e;

  // Which half / which quotient-remainder word the iterative unit returns
  typedef enum logic [1:0] {
    MD_MUL_LO,
    MD_MUL_HI,
    MD_DIV_Q,
    MD_DIV_R
  } md_mode_e;

  function automatic logic is_mdu_op(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_src1(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // MULHSU treats src2 as unsigned
  function automatic logic is_signed_src2(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic md_mode_e md_mode(op_e op);
    md_mode_e m;
    case (op)
      OP_MUL:                        m = MD_MUL_LO;
      OP_MULH, OP_MULHSU, OP_MULHU:  m = MD_MUL_HI;
      OP_DIV, OP_DIVU:               m = MD_DIV_Q;
      default:                       m = MD_DIV_R;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_mdu_muldiv_iter.sv
// Iterative radix-2 multiply (shift-add) / restoring divide on operand magnitudes.
// One step per cycle while step_i; final step and sign fixup are presented combinationally with done_c_o.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_i,
  input  md_mode_e        mode_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            neg_a_i,
  input  logic            neg_b_i,
  output logic            done_c_o,
  output logic [XLEN-1:0] res_c_o
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned AW  = 2 * XLEN;

  logic [AW-1:0]   acc_q, acc_step;
  logic [XLEN-1:0] b_q;
  logic [SHW-1:0]  cnt_q;
  md_mode_e        mode_q;
  logic            neg_a_q, neg_b_q;

  logic            is_div;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh, div_diff;
  logic            div_ge;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quo, rem;

  // Multiply: acc = {hi, multiplier}; divide: acc = {remainder, dividend/quotient}
  always_comb begin
    is_div   = (mode_q == MD_DIV_Q) || (mode_q == MD_DIV_R);
    mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = (div_sh >= {1'b0, b_q});
    if (is_div) begin
      acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
    quo  = (neg_a_q ^ neg_b_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_a_q ? -acc_step[AW-1:XLEN] : acc_step[AW-1:XLEN];
    case (mode_q)
      MD_MUL_LO: res_c_o = prod[XLEN-1:0];
      MD_MUL_HI: res_c_o = prod[AW-1:XLEN];
      MD_DIV_Q:  res_c_o = quo;
      default:   res_c_o = rem;
    endcase
  end

  assign done_c_o = step_i && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MD_MUL_LO;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (start_i) begin
      acc_q   <= {{XLEN{1'b0}}, a_i};
      b_q     <= b_i;
      cnt_q   <= SHW'(XLEN - 1);
      mode_q  <= mode_i;
      neg_a_q <= neg_a_i;
      neg_b_q <= neg_b_i;
    end else if (step_i) begin
      acc_q <= acc_step;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with handshaked iterative multiply/divide.
// Base ops and M-op special cases complete in one cycle; other M ops iterate XLEN cycles.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, out_valid_q, busy_q;

  op_e             op_w;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res, quick_res;
  logic            div_zero, signed_ovf, go_iter;
  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            md_start, md_done;
  logic [XLEN-1:0] md_res;

  assign op_w  = op_e'(op);
  assign shamt = src2[SHW-1:0];

  // Single-cycle base unit; unlisted codes give 0
  always_comb begin
    base_res = '0;
    case (op_w)
      OP_ADD:  base_res = src1 + src2;
      OP_SUB:  base_res = src1 - src2;
      OP_SLT:  base_res = XLEN'($signed(src1) < $signed(src2));
      OP_SLTU: base_res = XLEN'(src1 < src2);
      OP_GE:   base_res = XLEN'($signed(src1) >= $signed(src2));
      OP_GEU:  base_res = XLEN'(src1 >= src2);
      OP_AND:  base_res = src1 & src2;
      OP_OR:   base_res = src1 | src2;
      OP_XOR:  base_res = src1 ^ src2;
      OP_SLL:  base_res = src1 << shamt;
      OP_SRL:  base_res = src1 >> shamt;
      OP_SRA:  base_res = $signed(src1) >>> shamt;
      default: base_res = '0;
    endcase
  end

  // M-op special cases resolved at accept without iterating
  always_comb begin
    div_zero   = (op_w inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (src2 == '0);
    signed_ovf = (op_w inside {OP_DIV, OP_REM}) && (src1 == MOST_NEG) && (src2 == '1);
    if (div_zero) begin
      quick_res = (op_w inside {OP_DIV, OP_DIVU}) ? '1 : src1;
    end else if (signed_ovf) begin
      quick_res = (op_w == OP_DIV) ? MOST_NEG : '0;
    end else begin
      quick_res = base_res;
    end
    go_iter = is_mdu_op(op_w) && !div_zero && !signed_ovf;
    neg1    = is_signed_src1(op_w) && src1[XLEN-1];
    neg2    = is_signed_src2(op_w) && src2[XLEN-1];
    mag1    = neg1 ? -src1 : src1;
    mag2    = neg2 ? -src2 : src2;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    md_start = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_ITER: begin
        if (md_done) begin
          result_d = md_res;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready && !in_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    if (in_valid && in_ready) begin
      if (go_iter) begin
        md_start = 1'b1;
        state_d  = S_ITER;
      end else begin
        result_d = quick_res;
        state_d  = S_HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= (result_d == '0);
      out_valid_q <= (state_d == S_HOLD);
      busy_q      <= (state_d == S_ITER);
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .step_i   (state_q == S_ITER),
    .mode_i   (md_mode(op_w)),
    .a_i      (mag1),
    .b_i      (mag2),
    .neg_a_i  (neg1),
    .neg_b_i  (neg2),
    .done_c_o (md_done),
    .res_c_o  (md_res)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at XLEN=32 and XLEN=64 against a wide-arithmetic reference model.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, z32, busy32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        iv64, ir64, ov64, or64, z64, busy64;
  logic [4:0]  op64;
  logic [63:0] a64, b64, res64;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .src1(a32), .src2(b32), .out_valid(ov32), .out_ready(or32),
    .result(res32), .zero(z32), .busy(busy32)
  );

  alu_mdu #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .op(op64),
    .src1(a64), .src2(b64), .out_valid(ov64), .out_ready(or64),
    .result(res64), .zero(z64), .busy(busy64)
  );

  // Reference: exact wide signed arithmetic on w-bit operands
  function automatic logic [63:0] ref_model(input int w, input logic [4:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    logic signed [127:0] sa, sb, ua, ub, r;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ua = $signed({64'd0, a & mask});
    ub = $signed({64'd0, b & mask});
    sa = ua;
    sb = ub;
    if (a[w-1]) sa = ua - (128'sd1 <<< w);
    if (b[w-1]) sb = ub - (128'sd1 <<< w);
    sh = int'(b & 64'(w - 1));
    case (o)
      5'd0:  r = ua + ub;
      5'd1:  r = ua - ub;
      5'd2:  r = (sa < sb) ? 128'sd1 : 128'sd0;
      5'd3:  r = (ua < ub) ? 128'sd1 : 128'sd0;
      5'd4:  r = (sa >= sb) ? 128'sd1 : 128'sd0;
      5'd5:  r = (ua >= ub) ? 128'sd1 : 128'sd0;
      5'd6:  r = ua & ub;
      5'd7:  r = ua | ub;
      5'd8:  r = ua ^ ub;
      5'd9:  r = ua << sh;
      5'd10: r = ua >> sh;
      5'd11: r = sa >>> sh;
      5'd16: r = sa * sb;
      5'd17: r = (sa * sb) >>> w;
      5'd18: r = (sa * ub) >>> w;
      5'd19: r = (ua * ub) >>> w;
      5'd20: r = (ub == 0) ? -128'sd1 : sa / sb;
      5'd21: r = (ub == 0) ? -128'sd1 : ua / ub;
      5'd22: r = (ub == 0) ? sa : sa % sb;
      5'd23: r = (ub == 0) ? ua : ua % ub;
      default: r = 128'sd0;
    endcase
    return r[63:0] & mask;
  endfunction

  function automatic int exp_lat(input int w, input logic [4:0] o,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, mn;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn   = 64'd1 << (w - 1);
    if (o < 5'd16 || o > 5'd23) return 1;
    if (o >= 5'd20 && (b & mask) == 64'd0) return 1;
    if ((o == 5'd20 || o == 5'd22) && (a & mask) == mn && (b & mask) == mask) return 1;
    return w + 1;
  endfunction

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_8000_0000;
      3: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic logic [4:0] pick_op();
    logic [4:0] o;
    case ($urandom_range(0, 3))
      0: o = 5'($urandom_range(0, 31));
      1: o = 5'($urandom_range(0, 11));
      default: o = 5'(16 + $urandom_range(0, 7));
    endcase
    return o;
  endfunction

  // Issue one op to the idle 32-bit DUT, measure latency and busy cycles, then consume
  task automatic issue32(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output int lat, output int bcnt);
    @(negedge clk);
    iv32 = 1'b1; op32 = o; a32 = a; b32 = b; or32 = 1'b0;
    @(posedge clk); #1;
    iv32 = 1'b0; op32 = 5'($urandom); a32 = $urandom; b32 = $urandom;
    lat = 1; bcnt = 0;
    while (!ov32 && lat < 300) begin
      if (busy32) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    r = res32; z = z32;
    @(negedge clk); or32 = 1'b1;
    @(posedge clk); #1; or32 = 1'b0;
  endtask

  task automatic issue64(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output int lat, output int bcnt);
    @(negedge clk);
    iv64 = 1'b1; op64 = o; a64 = a; b64 = b; or64 = 1'b0;
    @(posedge clk); #1;
    iv64 = 1'b0; op64 = 5'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    lat = 1; bcnt = 0;
    while (!ov64 && lat < 300) begin
      if (busy64) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    r = res64;
    @(negedge clk); or64 = 1'b1;
    @(posedge clk); #1; or64 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv32 = 0; op32 = 0; a32 = 0; b32 = 0; or32 = 0;
    iv64 = 0; op64 = 0; a64 = 0; b64 = 0; or64 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (ir32 !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", ir32); end
    rst = 1'b0;
    #1;
    checks++;
    if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov32); end
    checks++;
    if (res32 !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", res32); end
    checks++;
    if (z32 !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", z32); end
    checks++;
    if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy32); end
    checks++;
    if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir32); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    logic [31:0] ex [3];
    ops = '{5'(OP_ADD), 5'(OP_SUB), 5'(OP_SRA)};
    as  = '{32'd5, 32'd3, 32'h8000_0000};
    bs  = '{32'd7, 32'd5, 32'd4};
    ex  = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000};
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv32 = 1'b1; op32 = ops[i]; a32 = as[i]; b32 = bs[i];
      @(posedge clk); #1;
      checks++;
      if (ov32 !== 1'b1 || res32 !== ex[i] || z32 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b result=%h zero=%b want valid=1 result=%h zero=0",
                 i, ov32, res32, z32, ex[i]);
      end
    end
    @(negedge clk); iv32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid=%b want 0", ov32); end
    or32 = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; logic z; int lat, bc;
    issue32(5'(OP_MULH), 32'hFFFF_FFFF, 32'd2, r, z, lat, bc);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_result: got %h want ffffffff", r); end
    checks++;
    if (lat !== 33 || bc !== 32) begin
      errors++; $display("FAIL mulh_timing: latency=%0d busy=%0d want 33/32", lat, bc);
    end
    issue32(5'(OP_MUL), 32'hFFFF_FFFF, 32'd2, r, z, lat, bc);
    checks++;
    if (r !== 32'hFFFF_FFFE || lat !== 33) begin
      errors++; $display("FAIL mul_lo: got %h lat %0d want fffffffe lat 33", r, lat);
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [5];
    logic [31:0] as [5];
    logic [31:0] bs [5];
    logic [31:0] ex [5];
    int          el [5];
    logic [31:0] r; logic z; int lat, bc;
    ops = '{5'(OP_DIV), 5'(OP_REM), 5'(OP_DIVU), 5'(OP_REM), 5'(OP_DIV)};
    as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000};
    bs  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};
    ex  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
    el  = '{33, 33, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      issue32(ops[i], as[i], bs[i], r, z, lat, bc);
      checks++;
      if (r !== ex[i] || lat !== el[i]) begin
        errors++;
        $display("FAIL div_case_%0d: got %h lat %0d want %h lat %0d", i, r, lat, ex[i], el[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    iv32 = 1'b1; op32 = 5'(OP_MUL); a32 = 32'hFFFF_FFFF; b32 = 32'd2; or32 = 1'b0;
    @(posedge clk); #1; iv32 = 1'b0;
    guard = 0;
    while (!ov32 && guard < 100) begin @(posedge clk); #1; guard++; end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (ov32 !== 1'b1 || res32 !== 32'hFFFF_FFFE || ir32 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b result=%h in_ready=%b want 1/fffffffe/0",
                 k, ov32, res32, ir32);
      end
    end
    @(negedge clk);
    or32 = 1'b1; iv32 = 1'b1; op32 = 5'(OP_ADD); a32 = 32'd3; b32 = 32'd4;
    @(posedge clk); #1; iv32 = 1'b0;
    checks++;
    if (ov32 !== 1'b1 || res32 !== 32'd7) begin
      errors++; $display("FAIL bp_accept: valid=%b result=%h want 1/00000007", ov32, res32);
    end
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0) begin errors++; $display("FAIL bp_release: valid=%b want 0", ov32); end
    or32 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic z; int lat, bc;
    @(negedge clk);
    iv32 = 1'b1; op32 = 5'(OP_MUL); a32 = 32'd1234; b32 = 32'd5678; or32 = 1'b0;
    @(posedge clk); #1; iv32 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (busy32 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy32); end
    rst = 1'b1;
    #1;
    checks++;
    if (ov32 !== 1'b0 || busy32 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: valid=%b busy=%b want 0/0", ov32, busy32);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (ir32 !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ir32); end
    issue32(5'(OP_ADD), 32'd1, 32'd1, r, z, lat, bc);
    checks++;
    if (r !== 32'd2 || lat !== 1) begin
      errors++; $display("FAIL mid_add: got %h lat %0d want 00000002 lat 1", r, lat);
    end
  endtask

  task automatic test_random32();
    logic [31:0] r, a, b, e; logic z; logic [4:0] o; int lat, bc, el;
    for (int i = 0; i < 60; i++) begin
      o = pick_op();
      a = 32'(pick_operand());
      b = 32'(pick_operand());
      if ($urandom_range(0, 3) == 0 && o >= 5'd20) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0 && o >= 5'd20) a = 32'h8000_0000;
      e  = 32'(ref_model(32, o, {32'd0, a}, {32'd0, b}));
      el = exp_lat(32, o, {32'd0, a}, {32'd0, b});
      issue32(o, a, b, r, z, lat, bc);
      checks++;
      if (r !== e || z !== (e == 32'd0) || lat !== el) begin
        errors++;
        $display("FAIL rand32_%0d op=%0d a=%h b=%h: got %h z=%b lat %0d want %h lat %0d",
                 i, o, a, b, r, z, lat, e, el);
      end
    end
  endtask

  task automatic test_xlen64();
    logic [63:0] r, a, b, e; logic [4:0] o; int lat, bc, el;
    issue64(5'(OP_MULHU), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bc);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 65 || bc !== 64) begin
      errors++; $display("FAIL x64_mulhu: got %h lat %0d busy %0d want fffffffffffffffe 65 64",
                         r, lat, bc);
    end
    issue64(5'(OP_SLL), 64'd1, 64'd63, r, lat, bc);
    checks++;
    if (r !== 64'h8000_0000_0000_0000 || lat !== 1) begin
      errors++; $display("FAIL x64_sll63: got %h lat %0d want 8000000000000000 lat 1", r, lat);
    end
    issue64(5'(OP_SLL), 64'd1, 64'd67, r, lat, bc);
    checks++;
    if (r !== 64'd8) begin errors++; $display("FAIL x64_sll_6bit: got %h want 8", r); end
    for (int i = 0; i < 16; i++) begin
      o  = pick_op();
      a  = pick_operand();
      b  = pick_operand();
      e  = ref_model(64, o, a, b);
      el = exp_lat(64, o, a, b);
      issue64(o, a, b, r, lat, bc);
      checks++;
      if (r !== e || lat !== el) begin
        errors++;
        $display("FAIL rand64_%0d op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                 i, o, a, b, r, lat, e, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    test_random32();
    test_xlen64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
